code_sender: RTL

- Initiator side of the combination-lock digit interface. Feeds the lock FSM one 4-bit digit per `insere` strobe.
- On `start`, captures an N-digit code and sends the digits MSD first, spaced by a fixed gap.
- Samples the lock's LED error indication after each digit.
- Reports pass or fail; used as an automated code entry / self-test master in front of the lock.

---
 rtl/code_sender_pkg.sv | 20 ++
 rtl/code_sender_if.sv | 29 ++
 rtl/code_sender_gap_timer.sv | 31 +++
 rtl/code_sender.sv | 139 +++++++++++++
 4 files changed

// File: rtl/code_sender_pkg.sv
// Shared types and constants for the combination-lock digit interface.
// Used by code_sender, its timer, the lock FSM and the benches.
package lock_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_GAP,
      S_CHECK,
      S_FINISH
   } state_e;

   localparam int          DIGIT_W   = 4;
   localparam logic [23:0] LOCK_CODE = 24'h590981;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
      return nibble <= 4'd9;
   endfunction

endpackage

// File: rtl/code_sender_if.sv
// Digit-interface bundle between code_sender (master) and the lock side (slave).
// bcd_err is present only when CODE_SENDER_BCD_CHECK_EN is defined.
interface code_sender_if #(
   parameter int N_DIGITS = 6,
   parameter int CNT_W    = 3
);
   logic                                  start;
   logic [lock_pkg::DIGIT_W*N_DIGITS-1:0] code;
   logic                                  led_in;
   logic [lock_pkg::DIGIT_W-1:0]          numero;
   logic                                  insere;
   logic                                  busy;
   logic                                  done;
   logic                                  ok;
   logic [CNT_W-1:0]                      digit_idx;
`ifdef CODE_SENDER_BCD_CHECK_EN
   logic                                  bcd_err;

   modport master (input start, code, led_in,
                   output numero, insere, busy, done, ok, digit_idx, bcd_err);
   modport slave  (output start, code, led_in,
                   input numero, insere, busy, done, ok, digit_idx, bcd_err);
`else
   modport master (input start, code, led_in,
                   output numero, insere, busy, done, ok, digit_idx);
   modport slave  (output start, code, led_in,
                   input numero, insere, busy, done, ok, digit_idx);
`endif
endinterface

// File: rtl/code_sender_gap_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module gap_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/code_sender.sv
// Sends an N-digit code to the lock MSD first, one insere strobe per digit, checking led_in after each.
// Optional CODE_SENDER_BCD_CHECK_EN rejects codes containing nibbles above 9 and flags bcd_err.
module code_sender
   import lock_pkg::*;
#(
   parameter int N_DIGITS   = 6,
   parameter int GAP_CYCLES = 4,
   parameter int CNT_W      = 3
) (
   input  logic          clk,
   input  logic          reset,
   code_sender_if.master bus
);
   localparam int              CODE_W   = DIGIT_W * N_DIGITS;
   localparam int              GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_DIGITS - 1);

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic                ok_q, ok_d;
   logic                pend_q, pend_d;
   logic                accept;
   logic                code_ok;
   logic                gap_load, gap_dec, gap_zero;

`ifdef CODE_SENDER_BCD_CHECK_EN
   logic bcd_err_q;

   always_comb begin
      code_ok = 1'b1;
      for (int unsigned i = 0; i < N_DIGITS; i++)
         if (!is_bcd(bus.code[i*DIGIT_W +: DIGIT_W]))
            code_ok = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bcd_err_q <= 1'b0;
      else if (accept)
         bcd_err_q <= !code_ok;
   end

   assign bus.bcd_err = bcd_err_q;
`else
   assign code_ok = 1'b1;
`endif

   gap_timer #(.W(GAP_W)) u_gap (
      .clk        (clk),
      .rst        (reset),
      .load_i     (gap_load),
      .load_val_i (GAP_W'(GAP_CYCLES - 1)),
      .dec_i      (gap_dec),
      .zero_o     (gap_zero)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      ok_d     = ok_q;
      pend_d   = pend_q;
      accept   = 1'b0;
      gap_load = 1'b0;
      gap_dec  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               pend_d  = 1'b0;
               state_d = S_SEND;
            end else if (bus.start) begin
               accept  = 1'b1;
               state_d = code_ok ? S_SEND : S_FINISH;
            end
         end
         S_SEND: begin
            gap_load = 1'b1;
            state_d  = S_GAP;
         end
         S_GAP: begin
            if (gap_zero) state_d = S_CHECK;
            else          gap_dec = 1'b1;
         end
         S_CHECK: begin
            if (bus.led_in) begin
               ok_d    = 1'b0;
               state_d = S_FINISH;
            end else if (idx_q == LAST_IDX) begin
               ok_d    = 1'b1;
               state_d = S_FINISH;
            end else begin
               shreg_d = shreg_q << DIGIT_W;
               idx_d   = idx_q + CNT_W'(1);
               state_d = S_SEND;
            end
         end
         S_FINISH: begin
            // A start here is captured now and replayed from IDLE via pend_q.
            state_d = S_IDLE;
            if (bus.start) begin
               accept = 1'b1;
               if (code_ok) pend_d  = 1'b1;
               else         state_d = S_FINISH;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         shreg_d = bus.code;
         idx_d   = '0;
         ok_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         ok_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         ok_q    <= ok_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.numero    = shreg_q[CODE_W-1 -: DIGIT_W];
   assign bus.insere    = (state_q == S_SEND);
   assign bus.busy      = (state_q != S_IDLE) || pend_q;
   assign bus.done      = (state_q == S_FINISH);
   assign bus.ok        = ok_q;
   assign bus.digit_idx = idx_q;

endmodule
